// File: rtl/rotation_sequencer.sv
// Iterative vector rotator: splits an angle into 80/70/60/40/30/20/10 degree
// micro-rotations and applies one shift-and-add step per clock. Option: ROT_ROUND_EN.
module rotation_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [7:0] y_in,
  input  logic [7:0] angle,
  output logic       busy,
  output logic       done,
  output logic [7:0] x_out,
  output logic [7:0] y_out,
  output logic [2:0] steps
);

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

  state_t     state_reg, state_next;
  logic [7:0] x_reg, y_reg;
  logic [8:0] rem_reg;
  logic [2:0] cnt_reg;
  logic [7:0] x_out_reg, y_out_reg;
  logic [2:0] steps_reg;

  logic [8:0] load_rem;
  logic [2:0] step_code;
  logic [8:0] rem_step;
  logic [2:0] cnt_step;
  logic [7:0] cur  [2];
  logic [7:0] nxt  [2];

  // Step code 1..7 maps to 10,20,30,40,60,70,80 degrees; 0 means no step fits.
  function automatic logic [2:0] step_pick(input logic [8:0] r);
    if (r >= 9'd80)      step_pick = 3'd7;
    else if (r >= 9'd70) step_pick = 3'd6;
    else if (r >= 9'd60) step_pick = 3'd5;
    else if (r >= 9'd40) step_pick = 3'd4;
    else if (r >= 9'd30) step_pick = 3'd3;
    else if (r >= 9'd20) step_pick = 3'd2;
    else if (r >= 9'd10) step_pick = 3'd1;
    else                 step_pick = 3'd0;
  endfunction

  function automatic logic [8:0] step_deg(input logic [2:0] code);
    case (code)
      3'd1:    step_deg = 9'd10;
      3'd2:    step_deg = 9'd20;
      3'd3:    step_deg = 9'd30;
      3'd4:    step_deg = 9'd40;
      3'd5:    step_deg = 9'd60;
      3'd6:    step_deg = 9'd70;
      3'd7:    step_deg = 9'd80;
      default: step_deg = 9'd0;
    endcase
  endfunction

  // Small angles shift right arithmetically, large ones shift left with zero fill.
  function automatic logic [7:0] rot_shift(input logic [7:0] v, input logic [2:0] code);
    case (code)
      3'd1:    rot_shift = $signed(v) >>> 3;
      3'd2:    rot_shift = $signed(v) >>> 2;
      3'd3:    rot_shift = $signed(v) >>> 1;
      3'd4:    rot_shift = v;
      3'd5:    rot_shift = v << 1;
      3'd6:    rot_shift = v << 2;
      3'd7:    rot_shift = v << 3;
      default: rot_shift = 8'd0;
    endcase
  endfunction

`ifdef ROT_ROUND_EN
  logic [8:0] angle_plus;
  assign angle_plus = {1'b0, angle} + 9'd5;
  assign load_rem   = (angle_plus / 9'd10) * 9'd10;
`else
  assign load_rem = {1'b0, angle};
`endif

  assign step_code = step_pick(rem_reg);
  assign rem_step  = rem_reg - step_deg(step_code);
  assign cnt_step  = cnt_reg + 3'd1;
  assign cur[0]    = x_reg;
  assign cur[1]    = y_reg;

  // Lane 0 is x (subtracts shifted y), lane 1 is y (adds shifted x).
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [7:0] shifted;
    assign shifted = rot_shift(cur[1-gi], step_code);
    if (gi == 0) begin : g_sub
      assign nxt[gi] = cur[gi] - shifted;
    end else begin : g_add
      assign nxt[gi] = cur[gi] + shifted;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = (load_rem >= 9'd10) ? ROT : DONE;
      ROT:  if (rem_step < 9'd10) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == ROT) || (state_reg == DONE);
    done = (state_reg == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg     <= 8'd0;
      y_reg     <= 8'd0;
      rem_reg   <= 9'd0;
      cnt_reg   <= 3'd0;
      x_out_reg <= 8'd0;
      y_out_reg <= 8'd0;
      steps_reg <= 3'd0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          x_reg   <= x_in;
          y_reg   <= y_in;
          rem_reg <= load_rem;
          cnt_reg <= 3'd0;
          if (load_rem < 9'd10) begin
            x_out_reg <= x_in;
            y_out_reg <= y_in;
            steps_reg <= 3'd0;
          end
        end
        ROT: begin
          x_reg   <= nxt[0];
          y_reg   <= nxt[1];
          rem_reg <= rem_step;
          cnt_reg <= cnt_step;
          // Result registers are refreshed only as the request completes.
          if (rem_step < 9'd10) begin
            x_out_reg <= nxt[0];
            y_out_reg <= nxt[1];
            steps_reg <= cnt_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign x_out = x_out_reg;
  assign y_out = y_out_reg;
  assign steps = steps_reg;

endmodule
